// File: rtl/tone_burst_tx.sv
// -----------------------------------------------------------------------------
// tone_burst_tx
//
// Acoustic command transmitter. A 2-bit command selects one of three
// square-wave tones (500 / 1000 / ~1500 Hz). The tone is played on the
// speaker pin for a fixed BURST_CYCLES, followed by a silent guard gap of
// GAP_CYCLES, after which a one-cycle done pulse is issued.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   burst request, sampled only while idle
//   command  in   2-bit command (0 invalid, 1 = 500 Hz, 2 = 1000 Hz, 3 = 1500 Hz)
//   abort    in   cancels a burst or gap in progress
//   speaker  out  square-wave drive, low whenever no tone plays
//   busy     out  high during tone and gap
//   done     out  one-cycle pulse on normal completion of burst plus gap
// -----------------------------------------------------------------------------
module tone_burst_tx #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int HALF_500     = 100_000,
    parameter int HALF_1000    = 50_000,
    parameter int HALF_1500    = 33_333,
    parameter int BURST_CYCLES = 125_000_000,
    parameter int GAP_CYCLES   = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] command,
    input  logic       abort,
    output logic       speaker,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [16:0] HALF_1     = 17'(HALF_500);
    localparam logic [16:0] HALF_2     = 17'(HALF_1000);
    localparam logic [16:0] HALF_3     = 17'(HALF_1500);
    localparam logic [26:0] BURST_LAST = 27'(BURST_CYCLES - 1);
    localparam logic [26:0] GAP_LAST   = 27'(GAP_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [16:0] half_reg, half_next;
    logic [16:0] half_cnt_reg, half_cnt_next;
    logic [26:0] burst_cnt_reg, burst_cnt_next;
    logic [26:0] gap_cnt_reg, gap_cnt_next;
    logic        speaker_reg, speaker_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    logic [16:0] half_sel;
    logic        accept;
    logic        abort_hit;
    logic        half_wrap;
    logic        burst_end;
    logic        gap_end;

    always_comb begin
        half_sel = 17'd0;
        case (command)
            2'd1:    half_sel = HALF_1;
            2'd2:    half_sel = HALF_2;
            2'd3:    half_sel = HALF_3;
            default: half_sel = 17'd0;
        endcase
    end

    assign accept    = start && (command != 2'd0);
    assign abort_hit = abort && (state_reg != IDLE);
    assign half_wrap = (half_cnt_reg == (half_reg - 17'd1));
    assign burst_end = (burst_cnt_reg == BURST_LAST);
    assign gap_end   = (gap_cnt_reg == GAP_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_next = state_reg;
        if (abort_hit) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (accept)    state_next = TONE;
                TONE:    if (burst_end) state_next = GAP;
                GAP:     if (gap_end)   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Next values for the registered outputs, counters and latched half-period.
    // Outputs are computed one edge ahead so that they change on the same edge
    // as the state transition that causes them.
    always_comb begin
        half_next      = half_reg;
        half_cnt_next  = half_cnt_reg;
        burst_cnt_next = burst_cnt_reg;
        gap_cnt_next   = gap_cnt_reg;
        speaker_next   = speaker_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;

        if (abort_hit) begin
            half_next      = 17'd0;
            half_cnt_next  = 17'd0;
            burst_cnt_next = 27'd0;
            gap_cnt_next   = 27'd0;
            speaker_next   = 1'b0;
            busy_next      = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        half_next      = half_sel;
                        half_cnt_next  = 17'd0;
                        burst_cnt_next = 27'd0;
                        gap_cnt_next   = 27'd0;
                        // First high level starts on the accepting edge
                        speaker_next   = 1'b1;
                        busy_next      = 1'b1;
                    end
                end
                TONE: begin
                    if (burst_end) begin
                        // Burst end truncates any partial half-period
                        half_cnt_next  = 17'd0;
                        burst_cnt_next = 27'd0;
                        gap_cnt_next   = 27'd0;
                        speaker_next   = 1'b0;
                    end else begin
                        burst_cnt_next = burst_cnt_reg + 27'd1;
                        if (half_wrap) begin
                            half_cnt_next = 17'd0;
                            speaker_next  = ~speaker_reg;
                        end else begin
                            half_cnt_next = half_cnt_reg + 17'd1;
                        end
                    end
                end
                GAP: begin
                    speaker_next = 1'b0;
                    if (gap_end) begin
                        gap_cnt_next = 27'd0;
                        busy_next    = 1'b0;
                        done_next    = 1'b1;
                    end else begin
                        gap_cnt_next = gap_cnt_reg + 27'd1;
                    end
                end
                default: begin
                    half_cnt_next  = 17'd0;
                    burst_cnt_next = 27'd0;
                    gap_cnt_next   = 27'd0;
                    speaker_next   = 1'b0;
                    busy_next      = 1'b0;
                end
            endcase
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_reg      <= 17'd0;
            half_cnt_reg  <= 17'd0;
            burst_cnt_reg <= 27'd0;
            gap_cnt_reg   <= 27'd0;
            speaker_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            half_reg      <= half_next;
            half_cnt_reg  <= half_cnt_next;
            burst_cnt_reg <= burst_cnt_next;
            gap_cnt_reg   <= gap_cnt_next;
            speaker_reg   <= speaker_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign speaker = speaker_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_tone_burst_tx.sv
// -----------------------------------------------------------------------------
// tb_tone_burst_tx
//
// Directed testbench for tone_burst_tx with small parameters
// (HALF 10/5/3, BURST 60, GAP 20). Outputs are sampled 1 ns after each
// rising edge; expected waveforms are computed from the edge index k
// counted from the accepting edge E0.
// -----------------------------------------------------------------------------
module tb_tone_burst_tx;

    localparam int H1 = 10;
    localparam int H2 = 5;
    localparam int H3 = 3;
    localparam int B  = 60;
    localparam int G  = 20;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] command;
    logic       abort;
    logic       speaker;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    tone_burst_tx #(
        .CLK_HZ       (100_000_000),
        .HALF_500     (H1),
        .HALF_1000    (H2),
        .HALF_1500    (H3),
        .BURST_CYCLES (B),
        .GAP_CYCLES   (G)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .command (command),
        .abort   (abort),
        .speaker (speaker),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one burst whose start request is already set up for the next
    // edge. Checks speaker/busy/done at edges E0..E0+B+G and counts
    // rising edges and done pulses. With spam=1 start keeps firing with
    // changing commands throughout the burst.
    task automatic burst(input string name, input int h, input bit spam);
        int  rises;
        int  dones;
        int  busy_cyc;
        int  wave_err;
        bit  prev;
        bit  exp_spk;
        bit  exp_busy;
        rises    = 0;
        dones    = 0;
        busy_cyc = 0;
        wave_err = 0;
        prev     = speaker;
        for (int k = 0; k <= B + G; k++) begin
            tick();
            exp_spk  = (k < B) ? (((k / h) % 2) == 0) : 1'b0;
            exp_busy = (k < B + G);
            if (speaker !== exp_spk || busy !== exp_busy) begin
                wave_err++;
                $display("FAIL %s wave k=%0d: observed spk=%0b busy=%0b expected spk=%0b busy=%0b",
                         name, k, speaker, busy, exp_spk, exp_busy);
            end
            if (speaker && !prev && k < B) rises++;
            prev = speaker;
            if (done) dones++;
            if (busy) busy_cyc++;
            if (spam && k < B + G - 1) begin
                start   = 1'b1;
                command = 2'(k % 4);
            end else begin
                start   = 1'b0;
            end
        end
        chk({name, " waveform"}, wave_err, 0);
        chk({name, " rises"}, rises, B / (2 * h));
        chk({name, " done count"}, dones, 1);
        chk({name, " done at end"}, int'(done), 1);
        chk({name, " busy cycles"}, busy_cyc, B + G);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        command = 2'd0;
        abort   = 1'b0;

        // Reset state
        #1;
        chk("reset speaker", int'(speaker), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Command 1: 500 Hz equivalent
        start = 1'b1; command = 2'd1;
        burst("cmd1", H1, 1'b0);
        tick();
        chk("cmd1 done cleared", int'(done), 0);

        // Command 3
        start = 1'b1; command = 2'd3;
        burst("cmd3", H3, 1'b0);
        tick();

        // Invalid command
        start = 1'b1; command = 2'd0;
        tick();
        tick();
        start = 1'b0;
        chk("invalid busy", int'(busy), 0);
        chk("invalid speaker", int'(speaker), 0);
        chk("invalid done", int'(done), 0);

        // Command 2 with start hammered every cycle
        start = 1'b1; command = 2'd2;
        burst("cmd2 spam", H2, 1'b1);
        tick();
        chk("spam no restart", int'(busy), 0);

        // Abort during TONE: abort sampled at edge E0+25
        start = 1'b1; command = 2'd1;
        tick();  // E0
        start = 1'b0;
        for (int k = 1; k < 25; k++) tick();
        abort = 1'b1;
        tick();  // E0+25
        abort = 1'b0;
        chk("abort speaker", int'(speaker), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        begin
            int late_done;
            late_done = 0;
            for (int k = 0; k < B + G; k++) begin
                tick();
                if (done || busy) late_done++;
            end
            chk("abort no later activity", late_done, 0);
        end

        // Fresh command-2 burst after abort
        start = 1'b1; command = 2'd2;
        burst("post-abort cmd2", H2, 1'b0);
        tick();

        // Asynchronous reset during GAP, mid-cycle
        start = 1'b1; command = 2'd1;
        tick();  // E0
        start = 1'b0;
        for (int k = 1; k <= B + 5; k++) tick();
        chk("pre-reset busy", int'(busy), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset busy", int'(busy), 0);
        chk("async reset speaker", int'(speaker), 0);
        chk("async reset done", int'(done), 0);
        tick();
        rst_n = 1'b1;

        // After release, command 1 then back-to-back command 2 on done
        start = 1'b1; command = 2'd1;
        burst("post-reset cmd1", H1, 1'b0);
        start = 1'b1; command = 2'd2;
        burst("back-to-back cmd2", H2, 1'b0);
        tick();
        chk("final idle busy", int'(busy), 0);
        chk("final done cleared", int'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
